// File: rtl/inert_intf_mc.sv
// inert_intf_mc: multi-channel inertial sensor front end.
// Configures the sensor over SPI, then reads enabled channels per INT.
module inert_intf_mc #(
  parameter logic [5:0] CH_MASK = 6'b000100,
  parameter int INIT_W = 16,
  parameter int TMO_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  input  logic        clr_err,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [95:0] data,
  output logic        vld,
  output logic        init_done,
  output logic        tmo_err
);

  typedef enum logic [2:0] {
    INIT_DLY,
    CFG,
    WAIT,
    RD_L,
    RD_H,
    VALID
  } state_t;

  // Lowest enabled channel, where every read set begins.
  function automatic logic [2:0] first_ch();
    first_ch = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (CH_MASK[i]) first_ch = 3'(i);
  endfunction

  // Next enabled channel above c; returns c itself when none is left.
  function automatic logic [2:0] next_ch(input logic [2:0] c);
    next_ch = c;
    for (int i = 5; i >= 0; i--)
      if (CH_MASK[i] && (i > int'(c))) next_ch = 3'(i);
  endfunction

  function automatic logic [7:0] l_addr(input logic [2:0] c);
    return 8'h22 + {4'b0000, c, 1'b0};
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [7:0] a);
    return {8'h80 | a, 8'h00};
  endfunction

  // Accel range write is only needed when an accel axis is enabled.
  function automatic logic [15:0] cfg_word(input logic [1:0] i);
    case (i)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1160;
      2'd2:    cfg_word = 16'h1440;
      default: cfg_word = 16'h1060;
    endcase
  endfunction

  localparam int N_CFG = (CH_MASK[5:3] != 3'b000) ? 4 : 3;
  localparam logic [1:0] CFG_LAST = 2'(N_CFG - 1);
  localparam logic [2:0] FIRST_CH = first_ch();
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic [INIT_W-1:0] DLY_ONES = '1;
  localparam logic [INIT_W-1:0] DLY_PRE = DLY_ONES - INIT_W'(1);

  state_t            state;
  logic [INIT_W-1:0] dly_cnt;
  logic [1:0]        cfg_idx;
  logic [2:0]        ch;
  logic [2:0]        nxt;
  logic [TW-1:0]     tmo_cnt;
  logic              int_m;
  logic              int_s;
  logic              tmo_hit;
  logic              unused_hi;

  assign unused_hi = ^rd_data[15:8];
  assign nxt = next_ch(ch);
  assign tmo_hit = (TMO_CYC != 0) && (state == WAIT) && !int_s &&
                   (tmo_cnt == TMO_LAST);

  // Two-flop synchroniser for the asynchronous data-ready line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_m <= 1'b0;
      int_s <= 1'b0;
    end else begin
      int_m <= INT;
      int_s <= int_m;
    end
  end

  // Timeout counter runs only while idle in WAIT with INT low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      if (state == WAIT && !int_s)
        tmo_cnt <= tmo_hit ? '0 : tmo_cnt + TW'(1);
      else
        tmo_cnt <= '0;
      if (tmo_hit)
        tmo_err <= 1'b1;
      else if (clr_err)
        tmo_err <= 1'b0;
    end
  end

  // Main sequencer: power-up delay, config writes, channel reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_DLY;
      dly_cnt   <= '0;
      cfg_idx   <= 2'd0;
      ch        <= 3'd0;
      wrt       <= 1'b0;
      cmd       <= 16'h0000;
      data      <= '0;
      vld       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        INIT_DLY: begin
          dly_cnt <= dly_cnt + INIT_W'(1);
          if (dly_cnt == DLY_PRE) begin
            wrt     <= 1'b1;
            cmd     <= cfg_word(2'd0);
            cfg_idx <= 2'd0;
            state   <= CFG;
          end
        end
        CFG: begin
          if (done) begin
            if (cfg_idx == CFG_LAST) begin
              init_done <= 1'b1;
              state     <= WAIT;
            end else begin
              cfg_idx <= cfg_idx + 2'd1;
              wrt     <= 1'b1;
              cmd     <= cfg_word(cfg_idx + 2'd1);
            end
          end
        end
        WAIT: begin
          if (int_s) begin
            ch    <= FIRST_CH;
            wrt   <= 1'b1;
            cmd   <= rd_cmd(l_addr(FIRST_CH));
            state <= RD_L;
          end
        end
        RD_L: begin
          if (done) begin
            data[{ch, 4'b0000} +: 8] <= rd_data[7:0];
            wrt   <= 1'b1;
            cmd   <= rd_cmd(l_addr(ch) + 8'd1);
            state <= RD_H;
          end
        end
        RD_H: begin
          if (done) begin
            data[{ch, 4'b1000} +: 8] <= rd_data[7:0];
            if (nxt != ch) begin
              ch    <= nxt;
              wrt   <= 1'b1;
              cmd   <= rd_cmd(l_addr(nxt));
              state <= RD_L;
            end else begin
              state <= VALID;
            end
          end
        end
        VALID: begin
          vld   <= 1'b1;
          state <= WAIT;
        end
        default: state <= INIT_DLY;
      endcase
    end
  end

endmodule

// File: tb/tb_inert_intf_mc.sv
// tb_inert_intf_mc: two instances (yaw-only with timeout, three
// channels with accel config) driven by a randomised SPI responder.
module tb_inert_intf_mc;

  localparam logic [5:0] MASK_A = 6'b000100;
  localparam logic [5:0] MASK_B = 6'b101001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        irq[2];
  logic        done[2];
  logic        clr_err[2];
  logic        wrt[2];
  logic        vld[2];
  logic        init_done[2];
  logic        tmo_err[2];
  logic [15:0] rd_data[2];
  logic [15:0] cmd[2];
  logic [95:0] data[2];

  int n_tests = 0;
  int n_fail = 0;

  logic        resp_en[2];
  logic        prev_wrt[2];
  int          pend[2];
  int          dcnt[2];
  int          ccnt[2];
  logic [15:0] pcmd[2];
  logic [15:0] clog[2][16];
  logic [7:0]  regs[2][128];
  int          fixed_lat;
  int          viol;

  inert_intf_mc #(.CH_MASK(MASK_A), .INIT_W(4), .TMO_CYC(10)) u_a (
    .clk(clk), .rst(rst[0]), .INT(irq[0]), .done(done[0]),
    .rd_data(rd_data[0]), .clr_err(clr_err[0]), .wrt(wrt[0]),
    .cmd(cmd[0]), .data(data[0]), .vld(vld[0]),
    .init_done(init_done[0]), .tmo_err(tmo_err[0]));

  inert_intf_mc #(.CH_MASK(MASK_B), .INIT_W(4), .TMO_CYC(0)) u_b (
    .clk(clk), .rst(rst[1]), .INT(irq[1]), .done(done[1]),
    .rd_data(rd_data[1]), .clr_err(clr_err[1]), .wrt(wrt[1]),
    .cmd(cmd[1]), .data(data[1]), .vld(vld[1]),
    .init_done(init_done[1]), .tmo_err(tmo_err[1]));

  // SPI monarch model: answers each wrt after a latency of 2..4 cycles.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (wrt[d] && prev_wrt[d]) viol++;
      if (wrt[d] && pend[d] != 0) viol++;
      prev_wrt[d] = wrt[d];
      if (resp_en[d]) begin
        done[d] = 1'b0;
        if (pend[d] > 0) begin
          pend[d]--;
          if (pend[d] == 0) begin
            done[d] = 1'b1;
            rd_data[d] = {8'($urandom), regs[d][pcmd[d][14:8]]};
            dcnt[d]++;
          end
        end
        if (wrt[d]) begin
          if (ccnt[d] < 16) clog[d][ccnt[d]] = cmd[d];
          ccnt[d]++;
          pcmd[d] = cmd[d];
          pend[d] = (fixed_lat != 0) ? fixed_lat
                                     : int'($urandom_range(4, 2));
        end
      end
    end
  end

  function automatic logic [255:0] pack_log(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      if (i < ccnt[d]) v[255-16*i -: 16] = clog[d][i];
    return v;
  endfunction

  function automatic int n_cfg(input logic [5:0] m);
    return (m[5:3] != 3'b000) ? 4 : 3;
  endfunction

  function automatic logic [255:0] exp_cfg(input logic [5:0] m);
    logic [255:0] v;
    v = '0;
    v[255:208] = 48'h0D02_1160_1440;
    if (m[5:3] != 3'b000) v[207:192] = 16'h1060;
    return v;
  endfunction

  function automatic int n_rd(input logic [5:0] m);
    int k;
    k = 0;
    for (int c = 0; c < 6; c++) if (m[c]) k += 2;
    return k;
  endfunction

  function automatic logic [255:0] exp_rd(input logic [5:0] m);
    logic [255:0] v;
    logic [7:0] a;
    int k;
    v = '0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (m[c]) begin
        a = 8'h22 + 8'(2 * c);
        v[255-16*k -: 16] = {8'h80 | a, 8'h00};
        v[239-16*k -: 16] = {8'h80 | (a + 8'h01), 8'h00};
        k += 2;
      end
    end
    return v;
  endfunction

  function automatic logic [95:0] exp_data(input int d, input logic [5:0] m);
    logic [95:0] v;
    v = '0;
    for (int c = 0; c < 6; c++)
      if (m[c])
        v[16*c +: 16] = {regs[d][8'h23 + 2*c], regs[d][8'h22 + 2*c]};
    return v;
  endfunction

  task automatic rand_regs(input int d);
    for (int a = 0; a < 128; a++) regs[d][a] = 8'($urandom);
  endtask

  // Bounded wait on one output; n = edges taken, -1 on expiry.
  task automatic wait_for(input int d, input int sel, input int max,
                          output int n);
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max) begin
      @(posedge clk);
      #1;
      n++;
      case (sel)
        0: hit = wrt[d];
        1: hit = init_done[d];
        2: hit = vld[d];
        default: hit = tmo_err[d];
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; irq[d] = 1'b0; done[d] = 1'b0;
      clr_err[d] = 1'b0; rd_data[d] = 16'h0;
      resp_en[d] = 1'b0; prev_wrt[d] = 1'b0;
      pend[d] = 0; dcnt[d] = 0; ccnt[d] = 0;
      rand_regs(d);
    end
    fixed_lat = 0;
    viol = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({wrt[d], cmd[d], data[d], vld[d], init_done[d], tmo_err[d]}
          !== 116'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got wrt=%b cmd=%h data=%h vld=%b init=%b tmo=%b, want all 0",
                 d, wrt[d], cmd[d], data[d], vld[d], init_done[d], tmo_err[d]);
      end
    end
  endtask

  task automatic test_init_a;
    int n;
    fixed_lat = 3;
    resp_en[0] = 1'b1;
    @(negedge clk) rst[0] = 1'b0;
    wait_for(0, 0, 100, n);
    n_tests++;
    if (n !== 15) begin
      n_fail++;
      $display("FAIL first_wrt_cycle: got %0d want 15", n);
    end
    n_tests++;
    if (cmd[0] !== 16'h0D02) begin
      n_fail++;
      $display("FAIL first_cfg_cmd: got %h want 0d02", cmd[0]);
    end
    wait_for(0, 1, 200, n);
    n_tests++;
    if (n < 0 || done[0] !== 1'b1 || dcnt[0] !== 3) begin
      n_fail++;
      $display("FAIL init_done_edge: got n=%0d done=%b dones=%0d want rise on 3rd done",
               n, done[0], dcnt[0]);
    end
    n_tests++;
    if ({ccnt[0], pack_log(0)} !== {n_cfg(MASK_A), exp_cfg(MASK_A)}) begin
      n_fail++;
      $display("FAIL cfg_seq_a: got %0d %h want %0d %h", ccnt[0],
               pack_log(0), n_cfg(MASK_A), exp_cfg(MASK_A));
    end
    fixed_lat = 0;
  endtask

  task automatic test_timeout;
    int n;
    wait_for(0, 3, 50, n);
    n_tests++;
    if (n !== 10) begin
      n_fail++;
      $display("FAIL tmo_delay: got %0d want 10", n);
    end
    repeat (9) @(posedge clk);
    @(negedge clk) clr_err[0] = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (tmo_err[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_set_wins: got %b want 1", tmo_err[0]);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (tmo_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear: got %b want 0", tmo_err[0]);
    end
    @(negedge clk) clr_err[0] = 1'b0;
  endtask

  task automatic test_yaw;
    int n;
    int extra;
    regs[0][8'h26] = 8'h34;
    regs[0][8'h27] = 8'h12;
    ccnt[0] = 0;
    @(negedge clk) irq[0] = 1'b1;
    wait_for(0, 0, 10, n);
    @(negedge clk) irq[0] = 1'b0;
    wait_for(0, 2, 100, n);
    n_tests++;
    if (n < 0 || data[0] !== exp_data(0, MASK_A) ||
        data[0][47:32] !== 16'h1234) begin
      n_fail++;
      $display("FAIL yaw_data: got n=%0d %h want %h", n, data[0],
               exp_data(0, MASK_A));
    end
    n_tests++;
    if ({ccnt[0], pack_log(0)} !== {n_rd(MASK_A), exp_rd(MASK_A)}) begin
      n_fail++;
      $display("FAIL yaw_cmds: got %0d %h want %0d %h", ccnt[0],
               pack_log(0), n_rd(MASK_A), exp_rd(MASK_A));
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (vld[0] || wrt[0]) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL yaw_single_vld: got %0d extra pulses want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int extra;
    rand_regs(0);
    ccnt[0] = 0;
    @(negedge clk) irq[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, 2, 100, n);
      n_tests++;
      if (n < 0 || data[0] !== exp_data(0, MASK_A)) begin
        n_fail++;
        $display("FAIL b2b_data set%0d: got %h want %h", k, data[0],
                 exp_data(0, MASK_A));
      end
      n_tests++;
      if ({ccnt[0], pack_log(0)} !== {n_rd(MASK_A), exp_rd(MASK_A)}) begin
        n_fail++;
        $display("FAIL b2b_cmds set%0d: got %0d %h", k, ccnt[0],
                 pack_log(0));
      end
      rand_regs(0);
      ccnt[0] = 0;
      if (k == 2) irq[0] = 1'b0;
      if (k < 3) begin
        @(posedge clk);
        #1;
        n_tests++;
        if ({vld[0], wrt[0]} !== 2'b01) begin
          n_fail++;
          $display("FAIL b2b_restart set%0d: got vld=%b wrt=%b want 0 1",
                   k, vld[0], wrt[0]);
        end
      end
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (wrt[0] || vld[0]) extra++;
    end
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL b2b_idle: got %0d pulses want 0", extra);
    end
  endtask

  task automatic test_multi_b;
    int n;
    resp_en[1] = 1'b1;
    @(negedge clk) rst[1] = 1'b0;
    wait_for(1, 1, 300, n);
    n_tests++;
    if (n < 0 ||
        {ccnt[1], pack_log(1)} !== {n_cfg(MASK_B), exp_cfg(MASK_B)}) begin
      n_fail++;
      $display("FAIL cfg_seq_b: got n=%0d %0d %h want %0d %h", n, ccnt[1],
               pack_log(1), n_cfg(MASK_B), exp_cfg(MASK_B));
    end
    rand_regs(1);
    ccnt[1] = 0;
    dcnt[1] = 0;
    @(negedge clk) irq[1] = 1'b1;
    wait_for(1, 0, 10, n);
    @(negedge clk) irq[1] = 1'b0;
    wait_for(1, 2, 200, n);
    n_tests++;
    if ({ccnt[1], pack_log(1)} !== {n_rd(MASK_B), exp_rd(MASK_B)}) begin
      n_fail++;
      $display("FAIL multi_order: got %0d %h want %0d %h", ccnt[1],
               pack_log(1), n_rd(MASK_B), exp_rd(MASK_B));
    end
    n_tests++;
    if (n < 0 || dcnt[1] !== 6) begin
      n_fail++;
      $display("FAIL multi_dones: got n=%0d dones=%0d want 6", n, dcnt[1]);
    end
    n_tests++;
    if (data[1] !== exp_data(1, MASK_B)) begin
      n_fail++;
      $display("FAIL multi_data: got %h want %h", data[1],
               exp_data(1, MASK_B));
    end
  endtask

  task automatic test_spurious_done;
    logic [95:0] keep;
    int extra;
    keep = data[1];
    resp_en[1] = 1'b0;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      done[1] = (i % 2 == 0);
      rd_data[1] = 16'($urandom);
      @(posedge clk);
      #1;
      if (wrt[1] || vld[1]) extra++;
    end
    @(negedge clk) done[1] = 1'b0;
    n_tests++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL spurious_wrt: got %0d pulses want 0", extra);
    end
    n_tests++;
    if (data[1] !== keep) begin
      n_fail++;
      $display("FAIL spurious_data: got %h want %h", data[1], keep);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic w;
    @(negedge clk) irq[0] = 1'b1;
    wait_for(0, 0, 20, n);
    wait_for(0, 0, 20, n);
    n_tests++;
    if (n < 0 || cmd[0] !== 16'hA700) begin
      n_fail++;
      $display("FAIL mid_reach_rdh: got n=%0d cmd=%h want a700", n, cmd[0]);
    end
    resp_en[0] = 1'b0;
    pend[0] = 0;
    irq[0] = 1'b0;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({wrt[0], cmd[0], data[0], vld[0], init_done[0], tmo_err[0]}
        !== 116'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got wrt=%b cmd=%h data=%h vld=%b init=%b",
               wrt[0], cmd[0], data[0], vld[0], init_done[0]);
    end
    @(negedge clk) rst[0] = 1'b0;
    @(posedge clk);
    #1;
    w = wrt[0];
    @(negedge clk);
    done[0] = 1'b1;
    rd_data[0] = 16'hFFFF;
    @(posedge clk);
    #1;
    w = w | wrt[0];
    @(negedge clk) done[0] = 1'b0;
    @(posedge clk);
    #1;
    w = w | wrt[0];
    fixed_lat = 3;
    ccnt[0] = 0;
    resp_en[0] = 1'b1;
    n_tests++;
    if (w !== 1'b0) begin
      n_fail++;
      $display("FAIL late_done_wrt: got %b want 0", w);
    end
    wait_for(0, 0, 40, n);
    n_tests++;
    if (n !== 12) begin
      n_fail++;
      $display("FAIL reinit_first_wrt: got %0d want 12", n);
    end
    wait_for(0, 1, 200, n);
    n_tests++;
    if (n < 0 ||
        {ccnt[0], pack_log(0)} !== {n_cfg(MASK_A), exp_cfg(MASK_A)}) begin
      n_fail++;
      $display("FAIL reinit_cfg: got n=%0d %0d %h", n, ccnt[0],
               pack_log(0));
    end
    fixed_lat = 0;
  endtask

  task automatic test_protocol;
    n_tests++;
    if (viol !== 0) begin
      n_fail++;
      $display("FAIL wrt_protocol: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_init_a();
    test_timeout();
    test_yaw();
    test_back_to_back();
    test_multi_b();
    test_spurious_done();
    test_reset_mid();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/inert_intf_mc.md
Name: inert_intf_mc

Overview:
- Parametrised, multi-channel successor to the single-axis inertial sensor interface.
- Runs a power-up configuration sequence over an SPI-monarch transaction port, then on each data-ready interrupt reads every enabled channel (gyro pitch/roll/yaw, accel x/y/z) as L then H bytes.
- Presents all channels as a packed word with a one-cycle valid pulse.
- Sits between the SPI monarch and the inertial integrator / navigation logic. Adds a sticky INT-timeout error that the previous generation lacked.

Parameters:
- CH_MASK, 6'b000100: channel enable, bit i = channel i. 0 ptch_rt (reg 0x22), 1 roll_rt (0x24), 2 yaw_rt (0x26), 3 ax (0x28), 4 ay (0x2A), 5 az (0x2C). Must be nonzero.
- INIT_W, 16: width of the power-up delay counter. The first config write is issued when the counter is all ones.
- TMO_CYC, 0: cycles allowed in WAIT without INT before tmo_err is set. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- INT  in  1  sensor data-ready, asynchronous (double-flopped internally)
- done  in  1  1-cycle pulse from SPI monarch, transaction complete
- rd_data  in  16  SPI read data; bits [7:0] valid when done=1
- clr_err  in  1  clears tmo_err
- wrt  out  1  1-cycle pulse, start SPI transaction
- cmd  out  16  SPI command word, registered; valid when wrt=1 and held until the next wrt
- data  out  96  channel i at data[16*i+15:16*i] = {H,L}; disabled channels read 0
- vld  out  1  1-cycle pulse when a full set of enabled channels is updated
- init_done  out  1  level; high once configuration completes, stays high until reset
- tmo_err  out  1  sticky timeout flag

Behaviour:
- Reset values: wrt=0, cmd=0, data=0, vld=0, init_done=0, tmo_err=0, state=INIT_DLY, delay counter=0, INT sync flops=0.
- States: INIT_DLY, CFG, WAIT, RD_L, RD_H, VALID.
- INIT_DLY: counter increments every cycle. When it is all ones: wrt=1, cmd=16'h0D02, go to CFG with cfg_idx=0.
- CFG, config list in order: 0x0D02, 0x1160, 0x1440, then 0x1060 only when CH_MASK[5:3]!=0.
  - On done, issue the next entry in the same cycle (wrt=1).
  - On done of the last entry: init_done<=1, go to WAIT. No wrt in that cycle.
- WAIT:
  - INT_sync (second flop) high: wrt=1, cmd={8'h80|L_addr(ch),8'h00} for the lowest enabled ch, go to RD_L.
  - The timeout counter counts while in WAIT and INT_sync is low. When it reaches TMO_CYC-1: tmo_err<=1, counter restarts, state stays WAIT.
  - The counter clears on leaving WAIT.
- RD_L: on done, latch rd_data[7:0] into the L byte of the current channel; same cycle wrt=1, cmd={8'h80|(L_addr+1),8'h00}; go to RD_H.
- RD_H: on done, latch the H byte.
  - If another enabled channel exists above the current one: advance to it, wrt=1 with its L command, go to RD_L.
  - Otherwise go to VALID.
- VALID: vld=1 for exactly one cycle, go to WAIT.
- data update rules:
  - data changes only on RD_L/RD_H done cycles. vld marks a coherent set.
  - Consumers sample data on vld. Bytes may be mid-update between vld pulses.
- done while no transaction is outstanding (WAIT, INIT_DLY, VALID) is ignored.
- wrt is never asserted on two consecutive cycles. At most one transaction is outstanding.
- INT still high on return to WAIT starts a new read set immediately; no edge detection.
- clr_err and a timeout on the same cycle: set wins.
- Reset asserted mid-transaction: immediate return to reset values. The next done after release is ignored (state INIT_DLY).
- Transactions per set = 2 × popcount(CH_MASK).
- Minimum latency from INT_sync high to vld = 2×N done round-trips + 1 cycle.

Test Plan:
- Power-up, INIT_W=4, CH_MASK=6'b000100, done returned 3 cycles after each wrt:
  - -> first wrt at cycle 15 with cmd 0x0D02, then 0x1160, 0x1440.
  - -> no 0x1060.
  - -> init_done rises on the third done.
- Yaw only: INT high, rd_data 0x34 then 0x12 -> cmds 0xA600 then 0xA700; data[47:32]=0x1234; one vld pulse; other slices 0.
- CH_MASK=6'b101001 -> config includes 0x1060.
  - -> read order A200, A300, A800, A900, AC00, AD00.
  - -> 6 done cycles, then vld; slices 0, 3, 5 loaded.
- TMO_CYC=10, INT held low after init -> tmo_err rises 10 cycles after entering WAIT.
- clr_err pulse coincident with timeout -> tmo_err stays 1. clr_err alone -> tmo_err 0.
- rst asserted in RD_H -> all outputs 0 next cycle. A late done after release causes no wrt. Re-init completes normally.
